sha256_w_expander_pipe: RTL and testbench
=========================================

# sha256_w_expander_pipe

- Parametrised, fully pipelined SHA-256 message-schedule expander for the double-SHA256 datapath.
- Accepts a 16-word W window and its round index. Emits the window advanced by STAGES×WPS words, with valid/ready handshaking, a backpressure stall and out-of-range detection.
- Sits between the block loader and the compression pipeline. It is the multi-word, multi-stage generalisation of the single-word W-memory stage.

## Interface
- STAGES, default 4: number of register stages, range 1..16.
- WPS, default 1: words generated per stage, range 1..4. STAGES×WPS must be ≤ 32; an elaboration check enforces this.
- CLK  in  1: clock; everything is sampled on the rising edge.
- RST  in  1: synchronous, active-high reset.
- in_valid  in  1: input window valid.
- in_ready  out  1: expander can accept the input this cycle.
- in_win  in  512: W[t]..W[t+15]; W[t] sits in bits [511:480].
- in_t  in  7: index t of the oldest word, legal range 0..48.
- in_dbl  in  1: block is the second hash of a double SHA (see Configuration).
- out_valid  out  1: output window valid.
- out_ready  in  1: consumer accepts the output.
- out_win  out  512: W[t+N]..W[t+N+15], where N = STAGES×WPS.
- out_t  out  7: in_t + N; no wrap is possible (max 80).
- out_ovf  out  1: at least one generated index exceeded 63.

## Operation
- Each generation step computes new = σ1(win[14]) + win[9] + σ0(win[1]) + win[0].
  - Addition is modulo 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - After each step the window shifts one word toward index 0 and `new` enters at position 15.
- A stage performs WPS chained steps combinationally, then registers the window, t, dbl and ovf with a valid bit.
- Generated absolute index j = t + 16 + k, where k counts steps already taken.
  - If j > 63: the word is forced to 0x00000000 and the stage's ovf bit is set.
  - ovf is sticky along the pipe (OR with the upstream value).
- Stall rule: stall = out_valid & ~out_ready.
  - While stall is high, every stage holds its data and valid bit.
  - in_ready = ~stall. There are no bubbles when unstalled, even if some stages are empty.
- Input is captured only when in_valid & in_ready. Otherwise stage 0 loads valid = 0 (data is don't-care but is held stable).
- in_t > 48 is illegal. Behaviour is defined only in that out_ovf = 1.

## Timing
- Latency: exactly STAGES cycles from an accepted input to out_valid, when no stall occurs.
- Throughput: one window per cycle.
- Under stall, out_win, out_t and out_ovf stay stable until the handshake completes.
- Reset, including mid-stream: all stage valid bits go to 0 on the next edge. out_valid = 0, out_win = 0, out_t = 0, out_ovf = 0. In-flight data is discarded.
- in_ready = 1 in the cycle after reset (stall is 0).
- Simultaneous out_ready = 1 and in_valid = 1 on a full pipe: the output retires and the input is accepted in the same cycle.

## Configuration
- Macro: SHA256_CME_CONST_EN.
- Defined: when in_dbl = 1 and in_t = 0, input words 8..15 are replaced before stage 0 with the fixed padding of a 256-bit message:
  - word 8 = 0x80000000;
  - words 9..14 = 0x00000000;
  - word 15 = 0x00000100.
  - The constant words are folded, so these input bits are ignored.
- Not defined: in_dbl is ignored, and all 16 words are taken from in_win.

## Test plan
- "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, t = 0), STAGES = 2, WPS = 1 -> after 2 cycles:
  - out_t = 2;
  - out_win word 14 = 0x61626380;
  - out_win word 15 = 0x000F0000;
  - out_ovf = 0.
- Same block, STAGES = 4, WPS = 4 -> out_t = 16. The words must match the reference W16..W31 (W16 = 0x61626380, W17 = 0x000F0000), checked against a software model.
- in_t = 48, any window, N = 2 -> words 14..15 = 0, out_ovf = 1, out_t = 50.
- Back-to-back stream of 20 windows with out_ready toggling pseudo-randomly -> all 20 arrive in order, none lost or duplicated, and the output is stable while stalled.
- RST asserted for 1 cycle while the pipe is full -> next cycle out_valid = 0, out_win = 0, in_ready = 1; a subsequent window arrives with normal latency.
- Macro defined, in_dbl = 1, t = 0, words 8..15 = 0xFFFFFFFF -> output equals that of the clean padded window. Macro undefined -> the output differs.

Source files
------------

// File: rtl/sha256_w_expander_pipe.sv
// Pipelined SHA-256 message-schedule expander: advances a 16-word W window by STAGES*WPS words.
// Optional `SHA256_CME_CONST_EN folds the fixed 256-bit padding into the second hash of a double SHA.
module sha256_w_expander_pipe #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WPS    = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_win,
  input  logic [6:0]   in_t,
  input  logic         in_dbl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_win,
  output logic [6:0]   out_t,
  output logic         out_ovf
);

  localparam int unsigned WIN_W   = 512;
  localparam int unsigned T_W     = 7;
  localparam int unsigned IDX_W   = 9;
  localparam int unsigned MAX_IDX = 63;
  localparam int unsigned MAX_T   = 48;

  if (STAGES < 1 || STAGES > 16 || WPS < 1 || WPS > 4 || STAGES * WPS > 32) begin : g_bad_cfg
    $error("sha256_w_expander_pipe: illegal STAGES/WPS combination");
  end

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  logic             valid_q [STAGES];
  logic [WIN_W-1:0] win_q   [STAGES];
  logic [T_W-1:0]   t_q     [STAGES];
  logic             ovf_q   [STAGES];
  logic             dbl_q   [STAGES];

  logic             valid_d [STAGES];
  logic [WIN_W-1:0] win_d   [STAGES];
  logic [T_W-1:0]   t_d     [STAGES];
  logic             ovf_d   [STAGES];
  logic             dbl_d   [STAGES];

  logic             src_valid [STAGES];
  logic [WIN_W-1:0] src_win   [STAGES];
  logic [T_W-1:0]   src_t     [STAGES];
  logic             src_ovf   [STAGES];
  logic             src_dbl   [STAGES];

  logic             stall;
  logic             accept;
  logic [WIN_W-1:0] fold_win;
  logic             unused_dbl;

  assign out_valid  = valid_q[STAGES-1];
  assign out_win    = win_q[STAGES-1];
  assign out_t      = t_q[STAGES-1];
  assign out_ovf    = ovf_q[STAGES-1];
  assign unused_dbl = dbl_q[STAGES-1];

  // Whole pipe freezes while the consumer refuses the head; empty stages are not compacted.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

`ifdef SHA256_CME_CONST_EN
  assign fold_win = (in_dbl && in_t == '0)
                  ? {in_win[511:256], 32'h8000_0000, 192'h0, 32'h0000_0100}
                  : in_win;
`else
  assign fold_win = in_win;
`endif

  // Stage inputs: stage 0 from the port, later stages from the previous register.
  always_comb begin
    src_valid[0] = accept;
    src_win[0]   = fold_win;
    src_t[0]     = in_t;
    src_ovf[0]   = (in_t > T_W'(MAX_T));
    src_dbl[0]   = in_dbl;
    for (int s = 1; s < int'(STAGES); s++) begin
      src_valid[s] = valid_q[s-1];
      src_win[s]   = win_q[s-1];
      src_t[s]     = t_q[s-1];
      src_ovf[s]   = ovf_q[s-1];
      src_dbl[s]   = dbl_q[s-1];
    end
  end

  // WPS chained schedule steps per stage; words past index 63 are zeroed and flagged.
  always_comb begin
    logic [WIN_W-1:0] w;
    logic [31:0]      nw;
    logic [IDX_W-1:0] idx;
    logic             ovf;
    w   = '0;
    nw  = '0;
    idx = '0;
    ovf = 1'b0;
    for (int s = 0; s < int'(STAGES); s++) begin
      w   = src_win[s];
      ovf = src_ovf[s];
      for (int k = 0; k < int'(WPS); k++) begin
        idx = IDX_W'(src_t[s]) + IDX_W'(16 + k);
        nw  = sig1(w[63:32]) + w[223:192] + sig0(w[479:448]) + w[511:480];
        if (idx > IDX_W'(MAX_IDX)) begin
          nw  = '0;
          ovf = 1'b1;
        end
        w = {w[479:0], nw};
      end
      valid_d[s] = src_valid[s];
      win_d[s]   = w;
      t_d[s]     = src_t[s] + T_W'(WPS);
      ovf_d[s]   = ovf;
      dbl_d[s]   = src_dbl[s];
    end
  end

  // Stage 0 keeps its data when nothing is accepted so the pipe holds stable values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        valid_q[s] <= 1'b0;
        win_q[s]   <= '0;
        t_q[s]     <= '0;
        ovf_q[s]   <= 1'b0;
        dbl_q[s]   <= 1'b0;
      end
    end else if (!stall) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        valid_q[s] <= valid_d[s];
        if (s != 0 || accept) begin
          win_q[s] <= win_d[s];
          t_q[s]   <= t_d[s];
          ovf_q[s] <= ovf_d[s];
          dbl_q[s] <= dbl_d[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_w_expander_pipe.sv
// Randomised bench for sha256_w_expander_pipe: two instances (N=2 and N=16) against a schedule-array model.
module tb_sha256_w_expander_pipe;

`ifdef SHA256_CME_CONST_EN
  localparam bit CONST_EN = 1'b1;
`else
  localparam bit CONST_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_dbl, out_ready, rand_ready;
  logic [511:0] in_win;
  logic [6:0]   in_t;
  logic         a_in_ready, a_out_valid, a_out_ovf;
  logic [511:0] a_out_win;
  logic [6:0]   a_out_t;
  logic         b_in_ready, b_out_valid, b_out_ovf;
  logic [511:0] b_out_win;
  logic [6:0]   b_out_t;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  sha256_w_expander_pipe #(.STAGES(2), .WPS(1)) u_a (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_win(in_win),
    .in_t(in_t), .in_dbl(in_dbl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_win(a_out_win), .out_t(a_out_t), .out_ovf(a_out_ovf)
  );

  sha256_w_expander_pipe #(.STAGES(4), .WPS(4)) u_b (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_win(in_win),
    .in_t(in_t), .in_dbl(in_dbl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_win(b_out_win), .out_t(b_out_t), .out_ovf(b_out_ovf)
  );

  task automatic check_eq(input string tag, input logic [520:0] got, input logic [520:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Expected {valid, window, t, ovf} after n schedule words, computed as a flat W array.
  function automatic logic [520:0] ref_out(input logic [511:0] win, input logic [6:0] t,
                                           input logic dbl, input int n);
    logic [31:0]  w [48];
    logic         ovf;
    logic [511:0] o;
    for (int i = 0; i < 16; i++) w[i] = win[511-32*i -: 32];
    if (CONST_EN && dbl && t == 7'd0) begin
      w[8] = 32'h8000_0000;
      for (int i = 9; i < 15; i++) w[i] = 32'h0;
      w[15] = 32'h0000_0100;
    end
    ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (int'(t) + 16 + k > 63) begin
        w[16+k] = 32'h0;
        ovf = 1'b1;
      end else begin
        w[16+k] = s1(w[k+14]) + w[k+9] + s0(w[k+1]) + w[k];
      end
    end
    for (int i = 0; i < 16; i++) o[511-32*i -: 32] = w[n+i];
    return {1'b1, o, 7'(int'(t) + n), ovf};
  endfunction

  function automatic logic [511:0] rand_win();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboards: accepted inputs are modelled, retired outputs are popped in order.
  logic [520:0] qa [$];
  logic [520:0] qb [$];
  int           na_acc = 0, na_out = 0;
  logic         a_hold = 1'b0, b_hold = 1'b0;
  logic [520:0] a_prev, b_prev;

  always @(negedge clk) begin
    logic [520:0] cur;
    cur = {a_out_valid, a_out_win, a_out_t, a_out_ovf};
    if (rst) begin
      qa.delete();
      a_hold = 1'b0;
    end else begin
      check_eq("a_in_ready", 521'(a_in_ready), 521'(!(a_out_valid && !out_ready)));
      if (a_hold) check_eq("a_stall_hold", cur, a_prev);
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) check_eq("a_spurious_out", 521'(1), 521'(0));
        else begin
          check_eq("a_out", cur, qa.pop_front());
          na_out++;
        end
      end
      if (in_valid && a_in_ready) begin
        qa.push_back(ref_out(in_win, in_t, in_dbl, 2));
        na_acc++;
      end
      a_hold = a_out_valid && !out_ready;
      a_prev = cur;
    end
  end

  always @(negedge clk) begin
    logic [520:0] cur;
    cur = {b_out_valid, b_out_win, b_out_t, b_out_ovf};
    if (rst) begin
      qb.delete();
      b_hold = 1'b0;
    end else begin
      check_eq("b_in_ready", 521'(b_in_ready), 521'(!(b_out_valid && !out_ready)));
      if (b_hold) check_eq("b_stall_hold", cur, b_prev);
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) check_eq("b_spurious_out", 521'(1), 521'(0));
        else check_eq("b_out", cur, qb.pop_front());
      end
      if (in_valid && b_in_ready) qb.push_back(ref_out(in_win, in_t, in_dbl, 16));
      b_hold = b_out_valid && !out_ready;
      b_prev = cur;
    end
  end

  // Single window with out_ready held high; checks exact latency of both instances.
  task automatic send_one(input logic [511:0] w, input logic [6:0] t, input logic d,
                          output logic [520:0] ra, output logic [520:0] rb);
    in_valid = 1'b1;
    in_win   = w;
    in_t     = t;
    in_dbl   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("a_lat_early", 521'(a_out_valid), 521'(0));
    @(negedge clk);
    check_eq("a_lat", 521'(a_out_valid), 521'(1));
    ra = {a_out_valid, a_out_win, a_out_t, a_out_ovf};
    @(negedge clk);
    check_eq("b_lat_early", 521'(b_out_valid), 521'(0));
    @(negedge clk);
    check_eq("b_lat", 521'(b_out_valid), 521'(1));
    rb = {b_out_valid, b_out_win, b_out_t, b_out_ovf};
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, w, wd, wc;
    logic [520:0] ra, rb, rd;
    int           base_acc, base_out;
    bit           acc;

    rst = 1'b1; in_valid = 1'b0; in_win = '0; in_t = '0; in_dbl = 1'b0;
    rand_ready = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_a_valid", 521'(a_out_valid), 521'(0));
    check_eq("rst_a_win",   521'(a_out_win),   521'(0));
    check_eq("rst_a_t",     521'(a_out_t),     521'(0));
    check_eq("rst_a_ovf",   521'(a_out_ovf),   521'(0));
    check_eq("rst_b_valid", 521'(b_out_valid), 521'(0));
    check_eq("rst_b_win",   521'(b_out_win),   521'(0));
    @(posedge clk); #1;

    abc = '0;
    abc[511:480] = 32'h6162_6380;
    abc[31:0]    = 32'h0000_0018;
    send_one(abc, 7'd0, 1'b0, ra, rb);
    check_eq("abc_a_t",   521'(ra[7:1]),   521'(2));
    check_eq("abc_a_w14", 521'(ra[71:40]), 521'(32'h6162_6380));
    check_eq("abc_a_w15", 521'(ra[39:8]),  521'(32'h000F_0000));
    check_eq("abc_a_ovf", 521'(ra[0]),     521'(0));
    check_eq("abc_b_t",   521'(rb[7:1]),   521'(16));
    check_eq("abc_b_w16", 521'(rb[519:488]), 521'(32'h6162_6380));
    check_eq("abc_b_w17", 521'(rb[487:456]), 521'(32'h000F_0000));
    check_eq("abc_b_ovf", 521'(rb[0]),     521'(0));

    send_one(rand_win(), 7'd48, 1'b0, ra, rb);
    check_eq("t48_a_t",   521'(ra[7:1]),  521'(50));
    check_eq("t48_a_w14", 521'(ra[71:40]), 521'(0));
    check_eq("t48_a_w15", 521'(ra[39:8]), 521'(0));
    check_eq("t48_a_ovf", 521'(ra[0]),    521'(1));
    check_eq("t48_b_win", 521'(rb[519:8]), 521'(0));
    check_eq("t48_b_ovf", 521'(rb[0]),    521'(1));

    for (int i = 0; i < 4; i++) send_one(rand_win(), 7'($urandom_range(0, 48)), 1'($urandom), ra, rb);

    // Stream of 20 windows into the N=2 instance under random backpressure.
    rand_ready = 1'b1;
    base_acc = na_acc;
    base_out = na_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_win   = rand_win();
      in_t     = 7'($urandom_range(0, 48));
      in_dbl   = 1'($urandom);
      acc      = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        acc = a_in_ready;
        @(posedge clk); #1;
      end
      if (!acc) check_eq("stream_accept_timeout", 521'(0), 521'(1));
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("stream_accepted", 521'(na_acc - base_acc), 521'(20));
    check_eq("stream_retired",  521'(na_out - base_out), 521'(20));
    check_eq("stream_a_drain",  521'(qa.size()), 521'(0));
    check_eq("stream_b_drain",  521'(qb.size()), 521'(0));

    // Fill both pipes, then reset for one cycle mid-stream.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_win   = rand_win();
      in_t     = 7'($urandom_range(0, 48));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_a_valid", 521'(a_out_valid), 521'(0));
    check_eq("midrst_a_win",   521'(a_out_win),   521'(0));
    check_eq("midrst_a_ready", 521'(a_in_ready),  521'(1));
    check_eq("midrst_b_valid", 521'(b_out_valid), 521'(0));
    check_eq("midrst_b_win",   521'(b_out_win),   521'(0));
    check_eq("midrst_b_ready", 521'(b_in_ready),  521'(1));
    @(posedge clk); #1;
    send_one(rand_win(), 7'($urandom_range(0, 48)), 1'b0, ra, rb);

    // Dirty tail words with in_dbl vs. the clean padded window.
    w  = rand_win();
    wd = w;
    wd[255:0] = {256{1'b1}};
    wc = w;
    wc[255:0] = {32'h8000_0000, 192'h0, 32'h0000_0100};
    send_one(wd, 7'd0, 1'b1, rd, rb);
    send_one(wc, 7'd0, 1'b0, ra, rb);
    check_eq("const_fold_match", 521'(rd == ra), 521'(CONST_EN));

    repeat (6) @(posedge clk);
    #1;
    check_eq("final_a_drain", 521'(qa.size()), 521'(0));
    check_eq("final_b_drain", 521'(qb.size()), 521'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
